// File: rtl/cla_acc_pkg.sv
// rtl/cla_acc_pkg.sv - shared types and helpers for the CLA stream accumulator
package cla_acc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } acc_state_t;

    localparam int unsigned DEF_CNTW = 8;

    // All-ones value of a w-bit counter, the saturation ceiling.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned CNT_MAX = cnt_max(DEF_CNTW);

endpackage

// File: rtl/NBitCarryLookaheadAdder.sv
// rtl/NBitCarryLookaheadAdder.sv - NBIT adder built from NBITTOCELL-wide lookahead cells
module NBitCarryLookaheadAdder #(
    parameter int unsigned NBIT       = 16,
    parameter int unsigned NBITTOCELL = 4
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic [NBIT-1:0] s,
    output logic            cout
);

    localparam int unsigned NCELL = NBIT / NBITTOCELL;

    logic [NBIT-1:0]  g;
    logic [NBIT-1:0]  p;
    logic [NBIT-1:0]  c;
    logic [NCELL:0]   gc;
    logic             carry;
    logic             prod;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry inside a cell is a flat sum of products over the cell's
    // generate/propagate terms; cells are chained by their carry-out.
    always_comb begin
        c     = '0;
        gc    = '0;
        carry = 1'b0;
        prod  = 1'b0;
        gc[0] = cin;
        for (int k = 0; k < int'(NCELL); k++) begin
            for (int j = 0; j <= int'(NBITTOCELL); j++) begin
                prod = gc[k];
                for (int l = 0; l < j; l++) begin
                    prod = prod & p[k*NBITTOCELL + l];
                end
                carry = prod;
                for (int m = 0; m < j; m++) begin
                    prod = g[k*NBITTOCELL + m];
                    for (int l = m + 1; l < j; l++) begin
                        prod = prod & p[k*NBITTOCELL + l];
                    end
                    carry = carry | prod;
                end
                if (j == int'(NBITTOCELL)) begin
                    gc[k+1] = carry;
                end else begin
                    c[k*NBITTOCELL + j] = carry;
                end
            end
        end
    end

    assign s    = p ^ c;
    assign cout = gc[NCELL];

endmodule

// File: rtl/cla_stream_accumulator.sv
// rtl/cla_stream_accumulator.sv - framed stream accumulator around a carry lookahead adder
module cla_stream_accumulator
    import cla_acc_pkg::*;
#(
    parameter int unsigned NBIT       = 16,
    parameter int unsigned NBITTOCELL = 4,
    parameter int unsigned CNTW       = DEF_CNTW,
    parameter int unsigned MAXOPS     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] out_sum,
    output logic [CNTW-1:0] out_ovf_cnt,
    output logic [CNTW-1:0] out_count
);

    localparam logic [CNTW-1:0] SAT_MAX  = CNTW'(cnt_max(CNTW));
    localparam logic [CNTW-1:0] OPS_LAST = CNTW'(MAXOPS);

    acc_state_t      state;
    acc_state_t      state_nxt;
    logic [NBIT-1:0] acc;
    logic [NBIT-1:0] add_a;
    logic [NBIT-1:0] add_s;
    logic            add_cout;
    logic [CNTW-1:0] ovf;
    logic [CNTW-1:0] ovf_nxt;
    logic [CNTW-1:0] cnt;
    logic            beat;
    logic            frame_end;

    assign in_ready    = (state != S_DONE);
    assign out_valid   = (state == S_DONE);
    assign out_sum     = acc;
    assign out_ovf_cnt = ovf;
    assign out_count   = cnt;

    assign beat  = in_valid & in_ready;
    // A new frame starts from zero regardless of what acc still holds.
    assign add_a = (state == S_IDLE) ? '0 : acc;

    NBitCarryLookaheadAdder #(
        .NBIT       (NBIT),
        .NBITTOCELL (NBITTOCELL)
    ) u_cla (
        .a    (add_a),
        .b    (in_data),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    assign ovf_nxt   = (add_cout && (ovf != SAT_MAX)) ? ovf + CNTW'(1) : ovf;
    assign frame_end = in_last |
                       ((state == S_IDLE) ? (MAXOPS == 1)
                                          : ((cnt + CNTW'(1)) == OPS_LAST));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ACCUM: begin
                if (beat) begin
                    state_nxt = frame_end ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            ovf   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                acc <= add_s;
                ovf <= ovf_nxt;
                cnt <= (state == S_IDLE) ? CNTW'(1) : cnt + CNTW'(1);
            end else if ((state == S_DONE) && out_ready) begin
                acc <= '0;
                ovf <= '0;
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cla_stream_accumulator.sv
// tb/tb_cla_stream_accumulator.sv - scoreboard bench for cla_stream_accumulator
module tb_cla_stream_accumulator;

    localparam int NBIT       = 16;
    localparam int NBITTOCELL = 4;
    localparam int CNTW       = 8;
    localparam int MAXOPS     = 16;

    typedef struct {
        logic [NBIT-1:0] sum;
        logic [CNTW-1:0] ovf;
        logic [CNTW-1:0] cnt;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] out_sum;
    logic [CNTW-1:0] out_ovf_cnt;
    logic [CNTW-1:0] out_count;

    logic rand_mode   = 1'b0;
    logic rnd_ready   = 1'b0;
    logic manual_ready = 1'b0;

    int     n_checks = 0;
    int     n_fail   = 0;
    res_t   exp_q[$];
    longint frame_total = 0;
    int     frame_n     = 0;

    always #5 clk = ~clk;

    assign out_ready = rand_mode ? rnd_ready : manual_ready;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 2) != 0);
    end

    cla_stream_accumulator #(
        .NBIT       (NBIT),
        .NBITTOCELL (NBITTOCELL),
        .CNTW       (CNTW),
        .MAXOPS     (MAXOPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_ovf_cnt (out_ovf_cnt),
        .out_count   (out_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sum of all frame operands as a plain integer; the wrapped
    // sum is its low bits and each wrap is one multiple of 2**NBIT.
    task automatic model_beat(input logic [NBIT-1:0] d, input logic last);
        frame_total += longint'(d);
        frame_n++;
        if (last || frame_n == MAXOPS) begin
            res_t   r;
            longint wraps;
            wraps = frame_total >> NBIT;
            r.sum = frame_total[NBIT-1:0];
            r.ovf = (wraps > 255) ? 8'hFF : 8'(wraps);
            r.cnt = 8'(frame_n);
            exp_q.push_back(r);
            frame_total = 0;
            frame_n     = 0;
        end
    endtask

    task automatic send(input logic [NBIT-1:0] d, input logic last);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
        end else begin
            @(posedge clk);
            model_beat(d, last);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result();
        manual_ready = 1'b1;
        @(posedge clk);
        #1;
        manual_ready = 1'b0;
    endtask

    // Monitor: every result hand-off pops one expected frame.
    always @(negedge clk) begin
        res_t r;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got sum 0x%0h count %0d, expected no result", out_sum, out_count);
            end else begin
                r = exp_q.pop_front();
                check("res_sum", 64'(out_sum), 64'(r.sum));
                check("res_ovf", 64'(out_ovf_cnt), 64'(r.ovf));
                check("res_count", 64'(out_count), 64'(r.cnt));
            end
        end
    end

    initial begin
        int t;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_ovf", 64'(out_ovf_cnt), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);

        send(16'h0001, 1'b0);
        send(16'h0001, 1'b1);
        check("t2_out_valid", 64'(out_valid), 64'd1);
        release_result();
        check("t2_after_valid", 64'(out_valid), 64'd0);

        repeat (2) send(16'hFFFF, 1'b0);
        send(16'hFFFF, 1'b1);
        check("t3_out_valid", 64'(out_valid), 64'd1);
        release_result();

        for (int i = 0; i < MAXOPS; i++) send(16'h1000, 1'b0);
        check("t4_out_valid", 64'(out_valid), 64'd1);
        check("t4_in_ready", 64'(in_ready), 64'd0);
        check("t4_count", 64'(out_count), 64'd16);

        in_valid = 1'b1;
        in_data  = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold_valid", 64'(out_valid), 64'd1);
            check("t5_hold_ready", 64'(in_ready), 64'd0);
            check("t5_hold_sum", 64'(out_sum), 64'h0000);
            check("t5_hold_ovf", 64'(out_ovf_cnt), 64'd1);
            check("t5_hold_count", 64'(out_count), 64'd16);
        end
        manual_ready = 1'b1;
        @(posedge clk);
        #1;
        manual_ready = 1'b0;
        in_valid     = 1'b0;
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_count", 64'(out_count), 64'd0);

        send(16'h0003, 1'b0);
        send(16'h0003, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        frame_total = 0;
        frame_n     = 0;
        check("t6_rst_count", 64'(out_count), 64'd0);
        send(16'h0005, 1'b1);
        check("t6_out_valid", 64'(out_valid), 64'd1);
        release_result();

        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [NBIT-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            send(d, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        send(16'h0042, 1'b1);

        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
